// File: rtl/frame_buffer_ctrl.sv
// Single-frame capture controller: queues bayer writes into the LRAM port, gives spi reads priority.
// Optional pixel counter enabled by defining FRAME_BUFFER_CTRL_PIXEL_COUNT_EN.
module frame_buffer_ctrl #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 30,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RAM_RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_req,
    input  logic              pix_fv,
    input  logic              pix_wr_en,
    input  logic [ADDR_W-1:0] pix_wr_addr,
    input  logic [DATA_W-1:0] pix_wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              frame_ready,
    output logic              busy,
    output logic [7:0]        overflow_cnt,
    output logic [7:0]        frame_count,
    output logic [31:0]       pixel_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DRAIN,
        S_READY
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    state_t            r_state;
    logic              r_fv;
    logic              r_busy;
    logic              r_frame_ready;
    logic [7:0]        r_frame_count;
    logic [7:0]        r_overflow_cnt;

    wr_entry_t         r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_ram_wr_en;
    logic [ADDR_W-1:0] r_ram_wr_addr;
    logic [DATA_W-1:0] r_ram_wr_data;

    logic [RAM_RD_LAT-1:0] r_rd_pipe;
    logic [ADDR_W-1:0] r_ram_rd_addr;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_fv_rise;
    logic              w_fv_fall;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_accept;
    logic              w_drop;

    assign w_fv_rise = !r_fv && pix_fv;
    assign w_fv_fall = r_fv && !pix_fv;
    assign w_push    = (r_state == S_CAPTURE) && pix_wr_en;
    assign w_pop     = (r_count != '0) && !rd_req;
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    // A full queue still takes a push when the same cycle frees a slot.
    assign w_accept  = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // Capture sequencer with registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_fv          <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_ready <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_fv <= pix_fv;
            case (r_state)
                S_IDLE: begin
                    if (capture_req) begin
                        r_state <= S_ARMED;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_fv_rise) r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (w_fv_fall) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((r_count == '0) && !r_ram_wr_en) begin
                        r_state       <= S_READY;
                        r_busy        <= 1'b0;
                        r_frame_ready <= 1'b1;
                        r_frame_count <= r_frame_count + 8'd1;
                    end
                end
                S_READY: begin
                    if (capture_req) begin
                        r_state       <= S_ARMED;
                        r_busy        <= 1'b1;
                        r_frame_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_busy        <= 1'b0;
                    r_frame_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_fifo[r_wr_ptr] <= '{addr: pix_wr_addr, data: pix_wr_data};
    end

    // Write queue bookkeeping and RAM write port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_overflow_cnt <= 8'd0;
            r_ram_wr_en    <= 1'b0;
            r_ram_wr_addr  <= '0;
            r_ram_wr_data  <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_accept && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_accept && w_pop) r_count <= r_count - CNT_W'(1);
            if (w_drop && (r_overflow_cnt != 8'hFF)) r_overflow_cnt <= r_overflow_cnt + 8'd1;
            r_ram_wr_en <= w_pop;
            if (w_pop) begin
                r_ram_wr_addr <= r_fifo[r_rd_ptr].addr;
                r_ram_wr_data <= r_fifo[r_rd_ptr].data;
            end
        end
    end

    // Read pipeline: bit 0 is the RAM read enable, the last bit marks data landing next edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pipe     <= '0;
            r_ram_rd_addr <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            r_rd_pipe[0] <= rd_req;
            for (int i = 1; i < int'(RAM_RD_LAT); i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            if (rd_req) r_ram_rd_addr <= rd_addr;
            r_rd_valid <= r_rd_pipe[RAM_RD_LAT-1];
            if (r_rd_pipe[RAM_RD_LAT-1]) r_rd_data <= ram_rd_data;
        end
    end

`ifdef FRAME_BUFFER_CTRL_PIXEL_COUNT_EN
    logic [31:0] r_pixel_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixel_count <= 32'd0;
        end else if ((r_state == S_ARMED) && w_fv_rise) begin
            r_pixel_count <= 32'd0;
        end else if (w_accept && (r_pixel_count != 32'hFFFF_FFFF)) begin
            r_pixel_count <= r_pixel_count + 32'd1;
        end
    end

    assign pixel_count = r_pixel_count;
`else
    assign pixel_count = 32'd0;
`endif

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign ram_wr_en    = r_ram_wr_en;
    assign ram_wr_addr  = r_ram_wr_addr;
    assign ram_wr_data  = r_ram_wr_data;
    assign ram_rd_en    = r_rd_pipe[0];
    assign ram_rd_addr  = r_ram_rd_addr;
    assign frame_ready  = r_frame_ready;
    assign busy         = r_busy;
    assign overflow_cnt = r_overflow_cnt;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl with a 2-cycle-latency RAM model.
module tb_frame_buffer_ctrl;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 30;
`ifdef FRAME_BUFFER_CTRL_PIXEL_COUNT_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              capture_req = 1'b0;
    logic              pix_fv = 1'b0;
    logic              pix_wr_en = 1'b0;
    logic [ADDR_W-1:0] pix_wr_addr = '0;
    logic [DATA_W-1:0] pix_wr_data = '0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              frame_ready;
    logic              busy;
    logic [7:0]        overflow_cnt;
    logic [7:0]        frame_count;
    logic [31:0]       pixel_count;

    int checks = 0;
    int failures = 0;
    int excl_err = 0;
    int wr_seen = 0;
    vec_t wlog[$];
    vec_t tbl[16];
    logic [DATA_W-1:0] mem [0:65535];

    frame_buffer_ctrl dut (
        .clk(clk), .reset(reset), .capture_req(capture_req), .pix_fv(pix_fv),
        .pix_wr_en(pix_wr_en), .pix_wr_addr(pix_wr_addr), .pix_wr_data(pix_wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .frame_ready(frame_ready), .busy(busy), .overflow_cnt(overflow_cnt),
        .frame_count(frame_count), .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;

    // RAM model: data for an enabled read is visible one cycle later and sampled by the DUT on the 2nd edge
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    always @(negedge clk) begin
        vec_t e;
        if (ram_wr_en && ram_rd_en) excl_err++;
        if (ram_wr_en) begin
            wr_seen++;
            e.addr = ram_wr_addr;
            e.data = ram_wr_data;
            wlog.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_data"},      32'(rd_data), 32'd0);
        check({tag, "_rd_valid"},     32'(rd_valid), 32'd0);
        check({tag, "_ram_wr_en"},    32'(ram_wr_en), 32'd0);
        check({tag, "_ram_wr_addr"},  32'(ram_wr_addr), 32'd0);
        check({tag, "_ram_wr_data"},  32'(ram_wr_data), 32'd0);
        check({tag, "_ram_rd_en"},    32'(ram_rd_en), 32'd0);
        check({tag, "_ram_rd_addr"},  32'(ram_rd_addr), 32'd0);
        check({tag, "_frame_ready"},  32'(frame_ready), 32'd0);
        check({tag, "_busy"},         32'(busy), 32'd0);
        check({tag, "_overflow_cnt"}, 32'(overflow_cnt), 32'd0);
        check({tag, "_frame_count"},  32'(frame_count), 32'd0);
        check({tag, "_pixel_count"},  pixel_count, 32'd0);
    endtask

    task automatic pulse_capture();
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
    endtask

    // mode 0: table addr/data, 1: table addr with junk data, 2: addr 0x200+i
    task automatic send_frame(input int n, input int mode);
        pix_fv = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            pix_wr_en   = 1'b1;
            pix_wr_addr = (mode == 2) ? ADDR_W'(32'h200 + 32'(i)) : tbl[i % 16].addr;
            pix_wr_data = (mode == 0) ? tbl[i % 16].data : DATA_W'(32'h3F00_0000 + 32'(i));
            pix_fv      = (i != n - 1);
            tick();
        end
        pix_wr_en = 1'b0;
        pix_fv    = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_ready(input int budget);
        int k = 0;
        while (!frame_ready && k < budget) begin
            tick();
            k++;
        end
        check("ready_timeout", 32'(frame_ready), 32'd1);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 16; i++) begin
            tbl[i].addr = (i == 15) ? 16'hFFFF : ADDR_W'(i);
            tbl[i].data = DATA_W'(32'h0ABC_0000 + 32'(i) * 32'h1111);
        end

        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Arm, capture frame 1, later frames must be ignored
        pulse_capture();
        check("armed_busy", 32'(busy), 32'd1);
        send_frame(16, 0);
        wait_ready(40);
        check("f1_frame_count", 32'(frame_count), 32'd1);
        check("f1_busy", 32'(busy), 32'd0);
        check("f1_pixel_count", pixel_count, PC_EN ? 32'd16 : 32'd0);
        check("f1_wr_count", 32'(wlog.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < wlog.size()) begin
                check($sformatf("f1_wr_addr_%0d", i), 32'(wlog[i].addr), 32'(tbl[i].addr));
                check($sformatf("f1_wr_data_%0d", i), 32'(wlog[i].data), 32'(tbl[i].data));
            end
        end
        for (int f = 0; f < 3; f++) send_frame(16, 1);
        check("f234_frame_count", 32'(frame_count), 32'd1);
        check("f234_no_writes", 32'(wlog.size()), 32'd16);
        check("f234_ready", 32'(frame_ready), 32'd1);

        // Four back-to-back reads at addrs 0..3
        for (int c = 0; c < 8; c++) begin
            rd_req  = (c < 4);
            rd_addr = tbl[c % 4].addr;
            tick();
            check($sformatf("rd4_en_%0d", c), 32'(ram_rd_en), (c < 4) ? 32'd1 : 32'd0);
            check($sformatf("rd4_valid_%0d", c), 32'(rd_valid), (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
            if (c >= 2 && c <= 5) check($sformatf("rd4_data_%0d", c), 32'(rd_data), 32'(tbl[c-2].data));
        end

        // Full table readback including address 0xFFFF
        for (int c = 0; c < 18; c++) begin
            rd_req  = (c < 16);
            rd_addr = tbl[c % 16].addr;
            tick();
            if (c < 16) check($sformatf("rdall_addr_%0d", c), 32'(ram_rd_addr), 32'(tbl[c].addr));
            if (c >= 2) begin
                check($sformatf("rdall_valid_%0d", c), 32'(rd_valid), 32'd1);
                check($sformatf("rdall_data_%0d", c), 32'(rd_data), 32'(tbl[c-2].data));
            end
        end
        rd_req = 1'b0;
        tick();

        // Re-arm from READY, then overflow the queue under read pressure
        pulse_capture();
        check("rearm_ready_low", 32'(frame_ready), 32'd0);
        check("rearm_busy", 32'(busy), 32'd1);
        pix_fv = 1'b1;
        tick();
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            rd_req      = 1'b1;
            rd_addr     = '0;
            pix_wr_en   = 1'b1;
            pix_wr_addr = ADDR_W'(32'h100 + 32'(i));
            pix_wr_data = DATA_W'(32'h2000 + 32'(i));
            capture_req = (i == 3);
            tick();
        end
        rd_req      = 1'b0;
        pix_wr_en   = 1'b0;
        capture_req = 1'b0;
        tick();
        check("ovf_cnt", 32'(overflow_cnt), 32'd2);
        for (int k = 0; k < 12; k++) tick();
        check("ovf_wr_count", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < wlog.size()) begin
                check($sformatf("ovf_wr_addr_%0d", i), 32'(wlog[i].addr), 32'h100 + 32'(i));
                check($sformatf("ovf_wr_data_%0d", i), 32'(wlog[i].data), 32'h2000 + 32'(i));
            end
        end
        check("ovf_busy_capture", 32'(busy), 32'd1);
        pix_fv = 1'b0;
        tick();
        wait_ready(40);
        check("ovf_frame_count", 32'(frame_count), 32'd2);
        check("ovf_pixel_count", pixel_count, PC_EN ? 32'd8 : 32'd0);
        check("ovf_cnt_hold", 32'(overflow_cnt), 32'd2);

        // Reset in the middle of a capture with 5 writes queued
        pulse_capture();
        pix_fv = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            rd_req      = 1'b1;
            pix_wr_en   = 1'b1;
            pix_wr_addr = ADDR_W'(32'h300 + 32'(i));
            pix_wr_data = DATA_W'(32'h5000 + 32'(i));
            tick();
        end
        reset     = 1'b1;
        rd_req    = 1'b0;
        pix_wr_en = 1'b0;
        pix_fv    = 1'b0;
        tick();
        check_all_zero("midrst");
        base  = wr_seen;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("midrst_no_writes", 32'(wr_seen - base), 32'd0);
        check("midrst_frame_count", 32'(frame_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);

        // 100-pixel frame after reset
        wlog.delete();
        pulse_capture();
        send_frame(100, 2);
        wait_ready(40);
        check("f100_frame_count", 32'(frame_count), 32'd1);
        check("f100_pixel_count", pixel_count, PC_EN ? 32'd100 : 32'd0);
        check("f100_wr_count", 32'(wlog.size()), 32'd100);
        check("f100_overflow", 32'(overflow_cnt), 32'd0);
        if (wlog.size() == 100) check("f100_last_addr", 32'(wlog[99].addr), 32'h200 + 32'd99);

        check("port_exclusive", 32'(excl_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
